ber_checker: RTL and testbench

Bit-error-rate checker that sits directly downstream of the Viterbi decoder in the tx/rx test chain. It captures the uncoded source bit stream fed to the convolutional encoder and the decoded bit stream leaving the decoder, and finds the decoder's latency in bits. Once locked, it counts compared bits and post-decoding bit errors so the bench can measure residual BER against the injected channel error rate.

---
 rtl/ber_checker.sv | 179 +++++++++++++++++
 tb/tb_ber_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_checker.sv
// ---------------------------------------------------------------------------
// ber_checker
//   Post-decoder bit-error-rate checker. Keeps a circular history of the
//   uncoded source bits, searches for the lag at which the decoded stream
//   lines up with that history, and once locked counts compared bits and
//   residual bit errors. Lock is dropped when too many errors fall inside
//   one monitoring window.
//
// Ports
//   clk, rst        : clock (rising edge) and asynchronous active-high reset
//   ref_valid_i/bit : source bit, same qualifier as the encoder enable
//   dec_valid_i/bit : decoded bit from the Viterbi decoder
//   clear_i         : zero the statistics (bit_ct, err_ct, sat); lock kept
//   locked_o        : alignment found
//   lat_o           : candidate lag while searching, locked lag otherwise
//   bit_ct_o        : bits compared while locked (saturating)
//   err_ct_o        : mismatches while locked (saturating)
//   err_pulse_o     : one-cycle pulse per counted mismatch
//   sat_o           : sticky, a statistics counter has hit its maximum
// ---------------------------------------------------------------------------
module ber_checker #(
   parameter int MAX_LAT    = 64,
   parameter int LOCK_LEN   = 32,
   parameter int WIN        = 64,
   parameter int UNLOCK_ERR = 8,
   parameter int CNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ref_valid_i,
   input  logic                       ref_bit_i,
   input  logic                       dec_valid_i,
   input  logic                       dec_bit_i,
   input  logic                       clear_i,
   output logic                       locked_o,
   output logic [$clog2(MAX_LAT)-1:0] lat_o,
   output logic [CNT_W-1:0]           bit_ct_o,
   output logic [CNT_W-1:0]           err_ct_o,
   output logic                       err_pulse_o,
   output logic                       sat_o
);

   localparam int LW  = $clog2(MAX_LAT);
   localparam int FW  = LW + 1;
   localparam int RW  = $clog2(LOCK_LEN + 1);
   localparam int WBW = $clog2(WIN + 1);
   localparam int WEW = $clog2(UNLOCK_ERR + 1);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           state_q;
   logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [LW-1:0]    lat_q;
   logic [LW-1:0]    rd_idx;
   logic [RW-1:0]    run_q;
   logic [WBW-1:0]   win_bits_q, win_bits_d;
   logic [WEW-1:0]   win_err_q, win_err_d;
   logic [CNT_W-1:0] bit_ct_q, bit_ct_d;
   logic [CNT_W-1:0] err_ct_q, err_ct_d;
   logic             sat_q, sat_d;
   logic             err_pulse_q;
   logic             ref_sel;
   logic             cmp_en;
   logic             match;
   logic             miss;
   logic             win_roll;
   logic             cnt_inc;

   logic buf_q [MAX_LAT];

   // History storage; contents are only ever read where fill says they exist.
   always_ff @(posedge clk) begin
      if (ref_valid_i) begin
         buf_q[wr_ptr_q] <= ref_bit_i;
      end
   end

   always_comb begin
      wr_ptr_d = ref_valid_i ? wr_ptr_q + LW'(1) : wr_ptr_q;
      fill_d   = (ref_valid_i && (fill_q != FW'(MAX_LAT))) ? fill_q + FW'(1) : fill_q;
      rd_idx   = wr_ptr_d - LW'(1) - lat_q;
      // At lag 0 with a write this cycle the target slot is the one being
      // written, so the incoming bit is forwarded instead of the stale slot.
      ref_sel  = (ref_valid_i && (lat_q == '0)) ? ref_bit_i : buf_q[rd_idx];
      cmp_en   = dec_valid_i && (fill_d > FW'(lat_q));
      match    = cmp_en && (dec_bit_i == ref_sel);
      miss     = cmp_en && (dec_bit_i != ref_sel);

      // A window that completed on the previous compare restarts here, so a
      // compare in this cycle becomes the first bit of the new window.
      win_roll   = (win_bits_q == WBW'(WIN));
      win_bits_d = (win_roll ? '0 : win_bits_q) + WBW'(cmp_en);
      win_err_d  = (win_roll ? '0 : win_err_q) + WEW'(miss);

      cnt_inc  = (state_q == ST_LOCKED) && cmp_en;
      bit_ct_d = bit_ct_q;
      err_ct_d = err_ct_q;
      if (cnt_inc && !(&bit_ct_q)) begin
         bit_ct_d = bit_ct_q + CNT_W'(1);
      end
      if (cnt_inc && miss && !(&err_ct_q)) begin
         err_ct_d = err_ct_q + CNT_W'(1);
      end
      sat_d = sat_q | (&bit_ct_d) | (&err_ct_d);
      if (clear_i) begin
         bit_ct_d = '0;
         err_ct_d = '0;
         sat_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SEARCH;
         lat_q       <= '0;
         run_q       <= '0;
         win_bits_q  <= '0;
         win_err_q   <= '0;
         bit_ct_q    <= '0;
         err_ct_q    <= '0;
         sat_q       <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         bit_ct_q    <= bit_ct_d;
         err_ct_q    <= err_ct_d;
         sat_q       <= sat_d;
         err_pulse_q <= 1'b0;
         case (state_q)
            ST_SEARCH: begin
               if (match) begin
                  if (run_q == RW'(LOCK_LEN - 1)) begin
                     state_q    <= ST_LOCKED;
                     run_q      <= '0;
                     win_bits_q <= '0;
                     win_err_q  <= '0;
                  end else begin
                     run_q <= run_q + RW'(1);
                  end
               end else if (miss) begin
                  run_q <= '0;
                  lat_q <= lat_q + LW'(1);
               end
            end
            ST_LOCKED: begin
               err_pulse_q <= miss;
               win_bits_q  <= win_bits_d;
               win_err_q   <= win_err_d;
               if (win_err_d == WEW'(UNLOCK_ERR)) begin
                  state_q <= ST_SEARCH;
                  run_q   <= '0;
               end
            end
            default: state_q <= ST_SEARCH;
         endcase
      end
   end

   assign locked_o    = (state_q == ST_LOCKED);
   assign lat_o       = lat_q;
   assign bit_ct_o    = bit_ct_q;
   assign err_ct_o    = err_ct_q;
   assign err_pulse_o = err_pulse_q;
   assign sat_o       = sat_q;

endmodule

// File: tb/tb_ber_checker.sv
// ---------------------------------------------------------------------------
// tb_ber_checker
//   Three checkers share one stimulus stream: default parameters, a 4-bit
//   counter build, and an 8-deep history build. Each is followed cycle by
//   cycle by a behavioural model built on a plain queue of every source bit
//   since reset, plus directed checks of the headline scenarios.
// ---------------------------------------------------------------------------
module tb_ber_checker;

   localparam int LOCK_LEN   = 32;
   localparam int WIN        = 64;
   localparam int UNLOCK_ERR = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ref_valid = 1'b0, ref_bit = 1'b0, dec_valid = 1'b0, dec_bit = 1'b0, clear = 1'b0;

   always #5 clk = ~clk;

   logic        locked0, locked1, locked2;
   logic [5:0]  lat0, lat1;
   logic [2:0]  lat2;
   logic [15:0] bit0, err0, bit2, err2;
   logic [3:0]  bit1, err1;
   logic        pulse0, pulse1, pulse2;
   logic        sat0, sat1, sat2;

   ber_checker u0 (
      .clk(clk), .rst(rst), .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
      .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clear_i(clear),
      .locked_o(locked0), .lat_o(lat0), .bit_ct_o(bit0), .err_ct_o(err0),
      .err_pulse_o(pulse0), .sat_o(sat0));

   ber_checker #(.CNT_W(4)) u1 (
      .clk(clk), .rst(rst), .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
      .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clear_i(clear),
      .locked_o(locked1), .lat_o(lat1), .bit_ct_o(bit1), .err_ct_o(err1),
      .err_pulse_o(pulse1), .sat_o(sat1));

   ber_checker #(.MAX_LAT(8)) u2 (
      .clk(clk), .rst(rst), .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
      .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clear_i(clear),
      .locked_o(locked2), .lat_o(lat2), .bit_ct_o(bit2), .err_ct_o(err2),
      .err_pulse_o(pulse2), .sat_o(sat2));

   int o_locked [3], o_lat [3], o_bit [3], o_err [3], o_pulse [3], o_sat [3];
   always_comb begin
      o_locked[0] = int'(locked0); o_locked[1] = int'(locked1); o_locked[2] = int'(locked2);
      o_lat[0]    = int'(lat0);    o_lat[1]    = int'(lat1);    o_lat[2]    = int'(lat2);
      o_bit[0]    = int'(bit0);    o_bit[1]    = int'(bit1);    o_bit[2]    = int'(bit2);
      o_err[0]    = int'(err0);    o_err[1]    = int'(err1);    o_err[2]    = int'(err2);
      o_pulse[0]  = int'(pulse0);  o_pulse[1]  = int'(pulse1);  o_pulse[2]  = int'(pulse2);
      o_sat[0]    = int'(sat0);    o_sat[1]    = int'(sat1);    o_sat[2]    = int'(sat2);
   end

   // Per-instance build parameters seen by the model.
   int max_lat [3] = '{64, 64, 8};
   int cnt_max [3] = '{65535, 15, 65535};

   // Model: src holds every source bit since reset, oldest first.
   bit src [$];
   int m_locked [3], m_lat [3], m_run [3], m_k [3], m_werr [3];
   int m_bit [3], m_err [3], m_pulse [3];

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_mis++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      src.delete();
      for (int i = 0; i < 3; i++) begin
         m_locked[i] = 0; m_lat[i] = 0; m_run[i] = 0; m_k[i] = 0; m_werr[i] = 0;
         m_bit[i] = 0; m_err[i] = 0; m_pulse[i] = 0;
      end
   endfunction

   function automatic void model_step(input bit rv, input bit rb, input bit dv,
                                      input bit db, input bit clr);
      int  fill;
      bit  hit;
      if (rv) src.push_back(rb);
      for (int i = 0; i < 3; i++) begin
         fill = (src.size() < max_lat[i]) ? src.size() : max_lat[i];
         m_pulse[i] = 0;
         if (dv && fill > m_lat[i]) begin
            hit = (db == src[src.size() - 1 - m_lat[i]]);
            if (m_locked[i] == 0) begin
               if (hit) begin
                  m_run[i]++;
                  if (m_run[i] == LOCK_LEN) begin
                     m_locked[i] = 1; m_run[i] = 0; m_k[i] = 0; m_werr[i] = 0;
                  end
               end else begin
                  m_run[i] = 0;
                  m_lat[i] = (m_lat[i] + 1) % max_lat[i];
               end
            end else begin
               // Windows are consecutive blocks of WIN compares since lock.
               if (m_k[i] % WIN == 0) m_werr[i] = 0;
               m_k[i]++;
               if (m_bit[i] < cnt_max[i]) m_bit[i]++;
               if (!hit) begin
                  if (m_err[i] < cnt_max[i]) m_err[i]++;
                  m_pulse[i] = 1;
                  m_werr[i]++;
                  if (m_werr[i] == UNLOCK_ERR) begin
                     m_locked[i] = 0; m_run[i] = 0;
                  end
               end
            end
         end
         if (clr) begin
            m_bit[i] = 0; m_err[i] = 0;
         end
      end
   endfunction

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("u%0d.locked", i), o_locked[i], m_locked[i]);
         check($sformatf("u%0d.lat", i),    o_lat[i],    m_lat[i]);
         check($sformatf("u%0d.bit_ct", i), o_bit[i],    m_bit[i]);
         check($sformatf("u%0d.err_ct", i), o_err[i],    m_err[i]);
         check($sformatf("u%0d.pulse", i),  o_pulse[i],  m_pulse[i]);
         check($sformatf("u%0d.sat", i),    o_sat[i],
               int'(m_bit[i] == cnt_max[i] || m_err[i] == cnt_max[i]));
      end
   endtask

   task automatic tick(input bit rv, input bit rb, input bit dv, input bit db, input bit clr);
      ref_valid = rv; ref_bit = rb; dec_valid = dv; dec_bit = db; clear = clr;
      @(posedge clk);
      model_step(rv, rb, dv, db, clr);
      #1;
      compare_all();
   endtask

   // One bit slot: new source bit plus the decoded bit 'lag' bits behind it.
   task automatic step(input int lag, input bit flip, input bit active, input bit clr);
      bit rb;
      bit dv;
      bit db;
      int idx;
      rb = 1'($urandom);
      if (!active) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0, clr);
      end else begin
         idx = src.size() - lag;
         if (lag == 0) begin
            dv = 1'b1; db = rb ^ flip;
         end else begin
            dv = (idx >= 0);
            db = dv ? (src[idx] ^ flip) : 1'b0;
         end
         tick(1'b1, rb, dv, db, clr);
      end
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("async_rst.locked", o_locked[0], 0);
      check("async_rst.bit_ct", o_bit[0], 0);
      compare_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   int base;
   int pulses;

   initial begin
      model_reset();
      #12;
      compare_all();
      $display("reset: outputs checked with rst high");
      @(negedge clk);
      rst = 1'b0;

      for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
      check("nofill.bit_ct", o_bit[0], 0);
      $display("dec_valid without reference: ignored");

      // Lock at lag 5
      for (int c = 0; c < 800 && o_locked[0] == 0; c++) step(5, 1'b0, 1'b1, 1'b0);
      check("lock.locked", o_locked[0], 1);
      check("lock.lat", o_lat[0], 5);
      for (int c = 0; c < 1000; c++) step(5, 1'b0, 1'b1, 1'b0);
      check("lock.bit_ct", o_bit[0], 1000);
      check("lock.err_ct", o_err[0], 0);
      check("lock.sat", o_sat[0], 0);
      check("lock.u1_bit_ct", o_bit[1], 15);
      check("lock.u1_sat", o_sat[1], 1);
      check("lock.u2_lat", o_lat[2], 5);
      $display("lock: lat=%0d bit_ct=%0d", o_lat[0], o_bit[0]);

      // Sparse errors: one flip in every 16
      base = o_err[0];
      pulses = 0;
      for (int j = 0; j < 256; j++) begin
         step(5, (j % 16) == 15, 1'b1, 1'b0);
         pulses += o_pulse[0];
      end
      check("sparse.err_delta", o_err[0] - base, 16);
      check("sparse.pulses", pulses, 16);
      check("sparse.locked", o_locked[0], 1);
      $display("sparse: err_ct=%0d pulses=%0d", o_err[0], pulses);

      // Burst of 8 aligned to a window start
      for (int c = 0; c < 200 && (m_k[0] % WIN) != 0; c++) step(5, 1'b0, 1'b1, 1'b0);
      base = o_err[0];
      for (int j = 0; j < 7; j++) step(5, 1'b1, 1'b1, 1'b0);
      check("burst.still_locked", o_locked[0], 1);
      step(5, 1'b1, 1'b1, 1'b0);
      check("burst.unlocked", o_locked[0], 0);
      check("burst.err_delta", o_err[0] - base, 8);
      check("burst.lat", o_lat[0], 5);
      for (int j = 0; j < 31; j++) step(5, 1'b0, 1'b1, 1'b0);
      check("relock.not_yet", o_locked[0], 0);
      step(5, 1'b0, 1'b1, 1'b0);
      check("relock.locked", o_locked[0], 1);
      check("relock.lat", o_lat[0], 5);
      $display("burst: unlocked and relocked at lat=%0d", o_lat[0]);

      // Saturation and clear on the 4-bit build
      step(5, 1'b0, 1'b1, 1'b1);
      check("clear.u1_bit_ct", o_bit[1], 0);
      check("clear.u1_sat", o_sat[1], 0);
      check("clear.u1_locked", o_locked[1], 1);
      check("clear.u0_bit_ct", o_bit[0], 0);
      for (int j = 0; j < 20; j++) step(5, 1'b0, 1'b1, 1'b0);
      check("sat.u1_bit_ct", o_bit[1], 15);
      check("sat.u1_sat", o_sat[1], 1);
      $display("saturation: u1 bit_ct=%0d sat=%0d", o_bit[1], o_sat[1]);

      // Same-cycle compare at lag 0 across buffer wraps
      async_reset();
      for (int j = 0; j < 100; j++) step(0, 1'b0, 1'b1, 1'b0);
      check("lag0.u2_locked", o_locked[2], 1);
      check("lag0.u2_lat", o_lat[2], 0);
      check("lag0.u2_err_ct", o_err[2], 0);
      check("lag0.u2_bit_ct", o_bit[2], 68);
      $display("lag0: u2 locked=%0d lat=%0d", o_locked[2], o_lat[2]);

      // Randomized traffic: stalls, flips and clears
      async_reset();
      for (int j = 0; j < 3000; j++)
         step(3, ($urandom_range(0, 11) == 0), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 63) == 0));
      $display("random: locked=%0d lat=%0d bit_ct=%0d err_ct=%0d",
               o_locked[0], o_lat[0], o_bit[0], o_err[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
